// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory handshake bundle for mem_port_arbiter
// Signals:
//   req0     fetch request, held until done0
//   req1     data request, held until done1
//   we1      data write enable, sampled when port 1 is granted
//   mem_ack  memory completion pulse
//   mem_sel  address/wdata mux select (0 = fetch, 1 = data)
//   mem_req  memory request
//   mem_we   memory write enable
//   gnt0     fetch port granted
//   gnt1     data port granted
//   done0    fetch access finished (ack or timeout)
//   done1    data access finished (ack or timeout)
//   err      access aborted by timeout
// Modports:
//   master   arbiter side: drives mem_sel/mem_req/mem_we/gnt*/done*/err
//   slave    pipeline and memory side: drives req0/req1/we1/mem_ack
interface mem_port_arbiter_if;
  logic req0;
  logic req1;
  logic we1;
  logic mem_ack;
  logic mem_sel;
  logic mem_req;
  logic mem_we;
  logic gnt0;
  logic gnt1;
  logic done0;
  logic done1;
  logic err;

  modport master (
    input  req0, req1, we1, mem_ack,
    output mem_sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err
  );

  modport slave (
    output req0, req1, we1, mem_ack,
    input  mem_sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (port 0) and data (port 1)
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    master modport of mem_port_arbiter_if
//          in : req0, req1, we1, mem_ack
//          out: mem_sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err
// Parameters:
//   MAX_WAIT  consecutive port-1 wins allowed while fetch is pending (>=1)
//   TIMEOUT   grant cycles without mem_ack before a forced abort (0 = never)
//   CNT_W     width of the wait and timeout counters
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  state_t           state;
  state_t           state_nx;
  logic             we1_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] to_cnt;

  logic in_grant;
  logic timeout;
  logic complete;
  logic arbitrate;
  logic arb_req0;
  logic arb_req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    in_grant  = (state == GRANT0) || (state == GRANT1);
    timeout   = TO_EN && in_grant && (to_cnt == TO_LAST) && !bus.mem_ack;
    complete  = in_grant && (bus.mem_ack || timeout);
    // Arbitrate from IDLE, or in the completion cycle so the next grant follows with no bubble.
    arbitrate = (state == IDLE) || complete;
    // The completing port still holds its req this cycle; it must not win again on stale req.
    arb_req0  = bus.req0 && (state != GRANT0);
    arb_req1  = bus.req1 && (state != GRANT1);

    state_nx = state;
    if (arbitrate) begin
      if (arb_req0 && (wait_cnt == WAIT_MAX)) state_nx = GRANT0;
      else if (arb_req1)                      state_nx = GRANT1;
      else if (arb_req0)                      state_nx = GRANT0;
      else                                    state_nx = IDLE;
    end

    bus.gnt0    = (state == GRANT0);
    bus.gnt1    = (state == GRANT1);
    bus.mem_sel = (state == GRANT1);
    bus.mem_req = in_grant;
    bus.mem_we  = (state == GRANT1) && we1_q;
    bus.done0   = (state == GRANT0) && complete;
    bus.done1   = (state == GRANT1) && complete;
    bus.err     = timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we1_q    <= 1'b0;
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      // we1 is captured once per data grant and held for the whole access.
      if (arbitrate && (state_nx == GRANT1)) we1_q <= bus.we1;

      if (arbitrate && (state_nx != IDLE))  to_cnt <= '0;
      else if (in_grant && !bus.mem_ack)    to_cnt <= to_cnt + 1'b1;

      if (!bus.req0)
        wait_cnt <= '0;
      else if (arbitrate && (state_nx == GRANT0))
        wait_cnt <= '0;
      else if (arbitrate && (state_nx == GRANT1) && arb_req0 && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_WAIT(MAX_WAIT),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port, how long it has held it, and how many
  // times data has overtaken a waiting fetch.
  int m_owner;   // -1 none, 0 fetch, 1 data
  int m_age;
  int m_wins;
  bit m_wl;

  logic [7:0] last_out;

  // Output vector order: {mem_sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err}
  typedef struct {
    logic       rn;
    logic       r0;
    logic       r1;
    logic       w;
    logic       a;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] sample_out();
    return {bus.mem_sel, bus.mem_req, bus.mem_we, bus.gnt0, bus.gnt1,
            bus.done0, bus.done1, bus.err};
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_age   = 0;
    m_wins  = 0;
    m_wl    = 1'b0;
  endfunction

  function automatic logic [7:0] model_out(input logic a);
    bit granted, tmo, fin;
    granted = (m_owner >= 0);
    tmo     = granted && (TIMEOUT != 0) && (m_age == TIMEOUT - 1) && !a;
    fin     = granted && (a || tmo);
    return {m_owner == 1, granted, (m_owner == 1) && m_wl, m_owner == 0, m_owner == 1,
            (m_owner == 0) && fin, (m_owner == 1) && fin, tmo};
  endfunction

  function automatic void model_step(input logic r0, input logic r1, input logic w, input logic a);
    bit granted, tmo, fin, p0, p1;
    int nxt;
    granted = (m_owner >= 0);
    tmo     = granted && (TIMEOUT != 0) && (m_age == TIMEOUT - 1) && !a;
    fin     = granted && (a || tmo);
    if (!granted || fin) begin
      p0 = r0 && (m_owner != 0);
      p1 = r1 && (m_owner != 1);
      if (p0 && m_wins >= MAX_WAIT) nxt = 0;
      else if (p1)                  nxt = 1;
      else if (p0)                  nxt = 0;
      else                          nxt = -1;
      if (nxt == 0) m_wins = 0;
      else if (nxt == 1 && p0 && m_wins < MAX_WAIT) m_wins = m_wins + 1;
      if (nxt == 1) m_wl = w;
      m_owner = nxt;
      m_age   = 0;
    end else begin
      m_age = m_age + 1;
    end
    if (!r0) m_wins = 0;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sel,req,we,gnt0,gnt1,done0,done1,err)", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cycle(input logic rn, input logic r0, input logic r1, input logic w,
                       input logic a, input bit has_exp, input logic [7:0] exp,
                       input string name);
    logic [7:0] got;
    @(negedge clk);
    rst_n       = rn;
    bus.req0    = r0;
    bus.req1    = r1;
    bus.we1     = w;
    bus.mem_ack = a;
    if (!rn) model_reset();
    #2;
    got = sample_out();
    check({name, " vs model"}, got, model_out(a));
    if (has_exp) check(name, got, exp);
    if (rn) model_step(r0, r1, w, a);
    last_out = got;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.we1     = 1'b0;
    bus.mem_ack = 1'b0;
    last_out    = 8'h00;
    model_reset();

    //                rn    r0    r1    w     a     expected
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'b00000000, "reset state"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00000000, "stray ack idle"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000000, "stays idle"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00000000, "fetch c0"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b01010000, "fetch c1"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b01010000, "fetch c2"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'b01010100, "fetch c3 done"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000000, "fetch c4 idle"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'b00000000, "collide c0"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11101000, "collide grant1 we held"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'b11101010, "collide done1"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b01010000, "collide grant0 no gap"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'b01010100, "collide done0"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000000, "collide idle"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b00000000, "read c0"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'b11001000, "read we latched 0"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'b11001010, "req1 dropped done1"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000000, "read idle"});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00000000, "drop0 c0"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b01010000, "req0 dropped grant0"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b01010100, "req0 dropped done0"});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00000000, "drop0 idle"});

    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].rn, vecs[i].r0, vecs[i].r1, vecs[i].w, vecs[i].a, 1'b1,
            vecs[i].exp, vecs[i].name);

    // Timeout without ack: abort in the 16th grant cycle.
    cycle(1, 0, 1, 0, 0, 1, 8'h00, "timeout c0");
    for (int k = 1; k <= TIMEOUT; k++)
      cycle(1, 0, 1, 0, 0, 1, (k == TIMEOUT) ? 8'b11001011 : 8'b11001000, "timeout grant");
    cycle(1, 0, 0, 0, 0, 1, 8'h00, "timeout idle");

    // Ack arriving in the would-be timeout cycle wins: no err.
    cycle(1, 0, 1, 0, 0, 1, 8'h00, "late ack c0");
    for (int k = 1; k <= TIMEOUT; k++)
      cycle(1, 0, 1, 0, (k == TIMEOUT), 1,
            (k == TIMEOUT) ? 8'b11001010 : 8'b11001000, "late ack grant");
    cycle(1, 0, 0, 0, 0, 1, 8'h00, "late ack idle");

    // Fetch held under continuous data pressure must keep getting the port.
    begin
      int run = 0;
      int max_run = 0;
      int g0_seen = 0;
      for (int k = 0; k < 60; k++) begin
        cycle(1, 1, !last_out[1], 1,
              last_out[6] && !last_out[2] && !last_out[1], 0, 8'h00, "starvation");
        if (last_out[1]) begin
          run++;
          if (run > max_run) max_run = run;
        end
        if (last_out[4] && !last_out[2]) begin
          run = 0;
          g0_seen++;
        end
      end
      check_int("starvation port1 run bounded", (max_run <= MAX_WAIT), 1);
      check_int("starvation fetch served", (g0_seen > 0), 1);
      check_int("starvation port1 served", (max_run > 0), 1);
    end
    cycle(1, 0, 0, 0, 0, 0, 8'h00, "drain");
    cycle(1, 0, 0, 0, 1, 0, 8'h00, "drain");
    cycle(1, 0, 0, 0, 0, 1, 8'h00, "drained idle");

    // Reset in the middle of a data access.
    cycle(1, 0, 1, 1, 0, 1, 8'h00,        "rst pre c0");
    cycle(1, 0, 1, 1, 0, 1, 8'b11101000,  "rst pre grant1");
    cycle(0, 1, 1, 1, 1, 1, 8'h00,        "rst mid-access");
    cycle(1, 1, 0, 0, 0, 1, 8'h00,        "rst release idle");
    cycle(1, 1, 0, 0, 0, 1, 8'b01010000,  "rst then grant0");
    cycle(1, 1, 0, 0, 1, 1, 8'b01010100,  "rst grant0 done");
    cycle(1, 0, 0, 0, 0, 1, 8'h00,        "rst final idle");

    // Random traffic against the model.
    begin
      logic r0 = 1'b0;
      logic r1 = 1'b0;
      logic w;
      logic a;
      logic rn;
      int   ack_pct;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 7) == 0) r0 = !r0;
        if ($urandom_range(0, 7) == 0) r1 = !r1;
        w       = 1'($urandom_range(0, 1));
        ack_pct = (((k / 150) % 3) == 2) ? 0 : 35;
        a       = (int'($urandom_range(0, 99)) < ack_pct);
        rn      = ($urandom_range(0, 299) != 0);
        cycle(rn, r0, r1, w, a, 0, 8'h00, "random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
